uart_rx_apb_drain: RTL and testbench

- APB master that sits directly in front of one CoreUARTapb instance: programs its baud/mode registers once after reset, then drains received bytes from its RX data register into a small byte FIFO.
- FIFO output is a valid/ready byte stream consumed by the processor-subsystem logic.
- Latches UART error flags into sticky status bits.

---
 rtl/uart_drain_pkg.sv | 37 +++
 rtl/uart_drain_fifo.sv | 61 ++++++
 rtl/uart_rx_apb_drain.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_rx_apb_drain.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_drain_pkg.sv
// Shared constants and types for the CoreUARTapb RX drain block.
package uart_drain_pkg;

    // CoreUARTapb register offsets on the 5-bit APB address bus
    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;

    // Bit positions inside the STATUS register
    localparam int STATUS_TXRDY    = 0;
    localparam int STATUS_RXRDY    = 1;
    localparam int STATUS_PARITY   = 2;
    localparam int STATUS_OVERFLOW = 3;
    localparam int STATUS_FRAMING  = 4;

    // Drain controller states
    typedef enum logic [2:0] {
        CFG1,
        CFG2,
        IDLE,
        ST_SETUP,
        ST_ACCESS,
        RD_SETUP,
        RD_ACCESS,
        HOLD
    } drain_state_e;

    // CTRL2 layout: {baud[12:8], odd_n_even, parity_en, bit8}
    function automatic logic [7:0] ctrl2_value(input logic [12:0] baud,
                                               input logic [1:0]  parity,
                                               input logic        bit8);
        return {baud[12:8], parity[1], parity[0], bit8};
    endfunction

endpackage

// File: rtl/uart_drain_fifo.sv
// Synchronous byte FIFO: power-of-two depth, wrapping pointers plus a
// separate occupancy count. Pop is only honoured while not empty; a push
// into a full FIFO is only accepted together with a pop.
module uart_drain_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [7:0]                  data_i,
    input  logic                        pop_i,
    output logic [7:0]                  data_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        full_o,
    output logic                        empty_o
);
    import uart_drain_pkg::*;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_en_s;
    logic             pop_en_s;

    assign empty_o   = (count_q == CNT_W'(0));
    assign full_o    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_en_s  = pop_i && !empty_o;
    assign push_en_s = push_i && (!full_o || pop_en_s);
    assign data_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage, pointers and count; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_en_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_en_s, pop_en_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_apb_drain.sv
// APB master in front of one CoreUARTapb: writes CTRL1/CTRL2 once after
// reset, then drains RXDATA into a byte FIFO presented as a valid/ready
// stream, and latches UART error flags into sticky bits.
// Optional build macro UART_RX_STATUS_POLL_EN: poll STATUS instead of
// using the RXRDY pin, and fold STATUS error bits into ERR_STICKY.
module uart_rx_apb_drain
    import uart_drain_pkg::*;
#(
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter logic        PRG_BIT8   = 1'b1,
    parameter logic [1:0]  PRG_PARITY = 2'b00,
    parameter int          FIFO_DEPTH = 8,
    parameter int          HOLDOFF    = 2
) (
    input  logic       PCLK,
    input  logic       PRESET,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [4:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       RXRDY,
    input  logic       PARITY_ERR,
    input  logic       FRAMING_ERR,
    input  logic       OVERFLOW,
    output logic [7:0] M_DATA,
    output logic       M_VALID,
    input  logic       M_READY,
    output logic       CFG_DONE,
    output logic [2:0] ERR_STICKY,
    input  logic       ERR_CLR
);

    localparam int         CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0] CTRL1_VAL = BAUD_VALUE[7:0];
    localparam logic [7:0] CTRL2_VAL = ctrl2_value(BAUD_VALUE, PRG_PARITY, PRG_BIT8);
    // Last HOLD count; a HOLDOFF of 0 or 1 still spends one cycle in HOLD
    localparam logic [7:0] HOLD_LAST = (HOLDOFF > 1) ? 8'(HOLDOFF - 1) : 8'd0;

    drain_state_e     state_q, state_d;
    logic             psel_q, psel_d;
    logic             penable_q, penable_d;
    logic             pwrite_q, pwrite_d;
    logic [4:0]       paddr_q, paddr_d;
    logic [7:0]       pwdata_q, pwdata_d;
    logic             cfg_done_q, cfg_done_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [2:0]       err_q, err_d;
    logic [2:0]       err_pin_q;
    logic [2:0]       err_pins_s;
    logic [2:0]       err_set_s;
    logic [2:0]       status_err_s;
    logic             push_s;
    logic             pop_s;
    logic             space_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;

    assign space_s    = (fifo_count_s < CNT_W'(FIFO_DEPTH));
    assign pop_s      = !fifo_empty_s && M_READY;
    assign err_pins_s = {OVERFLOW, FRAMING_ERR, PARITY_ERR};
    assign err_set_s  = (err_pins_s & ~err_pin_q) | status_err_s;

    uart_drain_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (push_s && (!fifo_full_s || pop_s)),
        .data_i  (PRDATA),
        .pop_i   (pop_s),
        .data_o  (M_DATA),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next state and next APB bus values; bus fields hold unless a transfer starts
    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        cfg_done_d   = cfg_done_q;
        hold_cnt_d   = hold_cnt_q;
        push_s       = 1'b0;
        status_err_s = 3'b000;
        case (state_q)
            CFG1, CFG2: begin
                if (!psel_q) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b1;
                    paddr_d   = (state_q == CFG1) ? ADDR_CTRL1 : ADDR_CTRL2;
                    pwdata_d  = (state_q == CFG1) ? CTRL1_VAL : CTRL2_VAL;
                end else if (!penable_q) begin
                    penable_d = 1'b1;
                end else if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    if (state_q == CFG1) begin
                        state_d = CFG2;
                    end else begin
                        state_d    = IDLE;
                        cfg_done_d = 1'b1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            IDLE: begin
`ifdef UART_RX_STATUS_POLL_EN
                if (space_s) begin
                    state_d   = ST_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = ADDR_STATUS;
                    pwdata_d  = 8'h00;
                end else begin
                    state_d = IDLE;
                end
`else
                if (RXRDY && space_s) begin
                    state_d   = RD_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = ADDR_RXDATA;
                    pwdata_d  = 8'h00;
                end else begin
                    state_d = IDLE;
                end
`endif
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
`ifdef UART_RX_STATUS_POLL_EN
                    status_err_s = {PRDATA[STATUS_OVERFLOW], PRDATA[STATUS_FRAMING],
                                    PRDATA[STATUS_PARITY]};
                    if (PRDATA[STATUS_RXRDY]) begin
                        state_d   = RD_SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        paddr_d   = ADDR_RXDATA;
                    end else begin
                        state_d   = IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
`else
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
`endif
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            RD_SETUP: begin
                penable_d = 1'b1;
                state_d   = RD_ACCESS;
            end
            RD_ACCESS: begin
                if (PREADY) begin
                    push_s     = 1'b1;
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    hold_cnt_d = 8'd0;
                    state_d    = HOLD;
                end else begin
                    state_d = RD_ACCESS;
                end
            end
            HOLD: begin
                // RXRDY is ignored here while the UART clears its flag
                if (hold_cnt_q >= HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = CFG1;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and registered APB outputs; reset aborts any transfer in flight
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q    <= CFG1;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= 5'h00;
            pwdata_q   <= 8'h00;
            cfg_done_q <= 1'b0;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            cfg_done_q <= cfg_done_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Sticky error update: a new set on the same edge as a clear survives
    always_comb begin
        if (ERR_CLR) begin
            err_d = err_set_s;
        end else begin
            err_d = err_q | err_set_s;
        end
    end

    // Error pin history for rising-edge detection, plus the sticky bits
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            err_pin_q <= 3'b000;
            err_q     <= 3'b000;
        end else begin
            err_pin_q <= err_pins_s;
            err_q     <= err_d;
        end
    end

    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign CFG_DONE   = cfg_done_q;
    assign ERR_STICKY = err_q;
    assign M_VALID    = !fifo_empty_s;

endmodule

// File: tb/tb_uart_rx_apb_drain.sv
// Scoreboard bench for uart_rx_apb_drain: stimulus pushes expected APB
// transfers and stream bytes into queues; a monitor pops and compares.
module tb_uart_rx_apb_drain;
    import uart_drain_pkg::*;

    typedef struct packed {
        logic       w;
        logic [4:0] a;
        logic [7:0] d;
    } apb_t;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       PSEL, PENABLE, PWRITE;
    logic [4:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA = 8'h00;
    logic       PREADY = 1'b1;
    logic       RXRDY = 1'b0;
    logic       PARITY_ERR = 1'b0;
    logic       FRAMING_ERR = 1'b0;
    logic       OVERFLOW = 1'b0;
    logic [7:0] M_DATA;
    logic       M_VALID;
    logic       M_READY = 1'b1;
    logic       CFG_DONE;
    logic [2:0] ERR_STICKY;
    logic       ERR_CLR = 1'b0;

    apb_t       exp_apb[$];
    logic [7:0] exp_byte[$];
    logic [7:0] uart_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic       pend_read = 1'b0;
    logic [4:0] cap_a = 5'h00;
    logic [7:0] cap_d = 8'h00;
    logic       cap_w = 1'b0;

    uart_rx_apb_drain #(
        .BAUD_VALUE (13'h1A3),
        .PRG_BIT8   (1'b1),
        .PRG_PARITY (2'b01),
        .FIFO_DEPTH (8),
        .HOLDOFF    (2)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .RXRDY       (RXRDY),
        .PARITY_ERR  (PARITY_ERR),
        .FRAMING_ERR (FRAMING_ERR),
        .OVERFLOW    (OVERFLOW),
        .M_DATA      (M_DATA),
        .M_VALID     (M_VALID),
        .M_READY     (M_READY),
        .CFG_DONE    (CFG_DONE),
        .ERR_STICKY  (ERR_STICKY),
        .ERR_CLR     (ERR_CLR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: APB completions and stream handshakes are checked against the queues
    always @(negedge PCLK) begin
        apb_t e;
        pend_read = PSEL && PENABLE && PREADY && !PWRITE && (PADDR == 5'h04);
        if (PSEL && !PENABLE) begin
            cap_a = PADDR;
            cap_d = PWDATA;
            cap_w = PWRITE;
        end
        if (PSEL && PENABLE && !PREADY) begin
            check("wait_paddr", 32'(PADDR), 32'(cap_a));
            check("wait_pwdata", 32'(PWDATA), 32'(cap_d));
            check("wait_pwrite", 32'(PWRITE), 32'(cap_w));
        end
        if (PSEL && PENABLE && PREADY) begin
            if (exp_apb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_xfer: got w=%0b addr=0x%0h data=0x%0h, expected none",
                         PWRITE, PADDR, PWDATA);
            end else begin
                e = exp_apb.pop_front();
                check("xfer_write", 32'(PWRITE), 32'(e.w));
                check("xfer_addr", 32'(PADDR), 32'(e.a));
                if (e.w) check("xfer_wdata", 32'(PWDATA), 32'(e.d));
            end
        end
        if (M_VALID && M_READY) begin
            if (exp_byte.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_byte: got 0x%0h, expected none", M_DATA);
            end else begin
                check("stream_data", 32'(M_DATA), 32'(exp_byte.pop_front()));
            end
        end
    end

    // UART model: RXDATA reads consume bytes; RXRDY is high while bytes wait
    always @(posedge PCLK) begin
        #1;
        if (pend_read && uart_q.size() != 0) void'(uart_q.pop_front());
        RXRDY  = (uart_q.size() != 0);
        PRDATA = (uart_q.size() != 0) ? uart_q[0] : 8'h00;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_apb_empty(input string name, input int limit);
        int n = 0;
        while (exp_apb.size() != 0 && n < limit) begin
            @(negedge PCLK);
            #1;
            n++;
        end
        check(name, 32'(exp_apb.size()), 32'd0);
    endtask

    task automatic wait_access(input string name, input int limit);
        int n = 0;
        while (!(PSEL && PENABLE) && n < limit) begin
            @(negedge PCLK);
            #1;
            n++;
        end
        check(name, 32'(PSEL && PENABLE), 32'd1);
    endtask

    task automatic offer(input logic [7:0] b, input logic expect_out);
        uart_q.push_back(b);
        exp_apb.push_back('{w: 1'b0, a: 5'h04, d: 8'h00});
        if (expect_out) exp_byte.push_back(b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        #3;
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_paddr", 32'(PADDR), 32'd0);
        check("rst_pwdata", 32'(PWDATA), 32'd0);
        check("rst_mvalid", 32'(M_VALID), 32'd0);
        check("rst_mdata", 32'(M_DATA), 32'd0);
        check("rst_cfg_done", 32'(CFG_DONE), 32'd0);
        check("rst_err", 32'(ERR_STICKY), 32'd0);

        // Configuration writes, CFG1 ACCESS stretched by 3 wait cycles
        PREADY = 1'b0;
        exp_apb.push_back('{w: 1'b1, a: 5'h08, d: 8'hA3});
        exp_apb.push_back('{w: 1'b1, a: 5'h0C, d: 8'h0B});
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        wait_access("cfg1_access_seen", 20);
        repeat (3) @(posedge PCLK);
        #1;
        check("cfg1_still_addr", 32'(PADDR), 32'h08);
        check("cfg1_still_enable", 32'(PENABLE), 32'd1);
        PREADY = 1'b1;
        n = 0;
        while (exp_apb.size() != 0 && n < 50) begin
            @(negedge PCLK);
            #1;
            n++;
        end
        check("cfg_writes_done", 32'(exp_apb.size()), 32'd0);
        check("cfg_done_before", 32'(CFG_DONE), 32'd0);
        @(negedge PCLK);
        #1;
        check("cfg_done_after", 32'(CFG_DONE), 32'd1);
        repeat (10) tick();

        // Single byte: M_VALID exactly one cycle, on the third edge after RXRDY
        offer(8'h5C, 1'b1);
        n = 0;
        while (!RXRDY && n < 10) begin
            @(negedge PCLK);
            #1;
            n++;
        end
        check("lat_rxrdy_seen", 32'(RXRDY), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge PCLK);
            #1;
            check($sformatf("lat_mvalid_%0d", k), 32'(M_VALID), 32'(k == 3));
            if (k == 3) check("lat_mdata", 32'(M_DATA), 32'h5C);
        end
        repeat (5) tick();

        // Backpressure: 9 bytes offered into an 8-deep FIFO
        M_READY = 1'b0;
        for (int i = 0; i < 9; i++) begin
            uart_q.push_back(8'h10 + 8'(i));
            exp_byte.push_back(8'h10 + 8'(i));
            if (i < 8) exp_apb.push_back('{w: 1'b0, a: 5'h04, d: 8'h00});
        end
        repeat (80) tick();
        check("full_reads_done", 32'(exp_apb.size()), 32'd0);
        check("full_byte_left", 32'(uart_q.size()), 32'd1);
        check("full_mvalid", 32'(M_VALID), 32'd1);
        exp_apb.push_back('{w: 1'b0, a: 5'h04, d: 8'h00});
        M_READY = 1'b1;
        repeat (3) @(posedge PCLK);
        #1 M_READY = 1'b0;
        repeat (30) tick();
        check("ninth_read_done", 32'(exp_apb.size()), 32'd0);
        check("ninth_byte_taken", 32'(uart_q.size()), 32'd0);
        check("after_pops_left", 32'(exp_byte.size()), 32'd6);
        M_READY = 1'b1;
        n = 0;
        while (exp_byte.size() != 0 && n < 30) begin
            @(negedge PCLK);
            #1;
            n++;
        end
        check("drain_done", 32'(exp_byte.size()), 32'd0);
        @(negedge PCLK);
        #1;
        check("drain_empty", 32'(M_VALID), 32'd0);

        // Sticky errors: framing edge, then clear together with a parity edge
        tick();
        FRAMING_ERR = 1'b1;
        tick();
        FRAMING_ERR = 1'b0;
        check("err_framing", 32'(ERR_STICKY), 32'b010);
        ERR_CLR = 1'b1;
        PARITY_ERR = 1'b1;
        tick();
        check("err_clr_parity", 32'(ERR_STICKY), 32'b001);
        ERR_CLR = 1'b0;
        PARITY_ERR = 1'b0;
        OVERFLOW = 1'b1;
        repeat (3) tick();
        check("err_overflow", 32'(ERR_STICKY), 32'b101);
        OVERFLOW = 1'b0;
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check("err_cleared", 32'(ERR_STICKY), 32'b000);

        // Reset during an RXDATA ACCESS with two bytes queued
        M_READY = 1'b0;
        offer(8'hA1, 1'b0);
        offer(8'hA2, 1'b0);
        wait_apb_empty("two_reads_done", 40);
        repeat (4) tick();
        PREADY = 1'b0;
        offer(8'hA3, 1'b0);
        wait_access("rd_access_seen", 20);
        check("queued_mvalid", 32'(M_VALID), 32'd1);
        #2 PRESET = 1'b1;
        exp_apb.delete();
        uart_q.delete();
        exp_byte.delete();
        #1;
        check("abort_psel", 32'(PSEL), 32'd0);
        check("abort_penable", 32'(PENABLE), 32'd0);
        check("abort_mvalid", 32'(M_VALID), 32'd0);
        check("abort_cfg_done", 32'(CFG_DONE), 32'd0);
        PREADY = 1'b1;
        repeat (3) tick();
        exp_apb.push_back('{w: 1'b1, a: 5'h08, d: 8'hA3});
        exp_apb.push_back('{w: 1'b1, a: 5'h0C, d: 8'h0B});
        PRESET = 1'b0;
        wait_apb_empty("recfg_done", 50);
        @(negedge PCLK);
        #1;
        check("recfg_cfg_done", 32'(CFG_DONE), 32'd1);
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
